// File: rtl/cpu_pkg.sv
// Shared constants for the multi-cycle CPU: opcodes, ALU controls, FSM states.
// Pure declarations, no latency; no flow control.
// Backpressure: not applicable.
package cpu_pkg;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_NOR  = 4'b0100;
   localparam logic [3:0] OP_NAND = 4'b0101;
   localparam logic [3:0] OP_SLT  = 4'b0110;
   localparam logic [3:0] OP_ADDI = 4'b0111;
   localparam logic [3:0] OP_LW   = 4'b1000;
   localparam logic [3:0] OP_SW   = 4'b1001;
   localparam logic [3:0] OP_BEQ  = 4'b1010;
   localparam logic [3:0] OP_BNE  = 4'b1011;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_NOR  = 4'b1100;
   localparam logic [3:0] ALU_NAND = 4'b1101;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] FETCH  = 3'd1;
   localparam logic [2:0] DECODE = 3'd2;
   localparam logic [2:0] EXEC   = 3'd3;
   localparam logic [2:0] MEM    = 3'd4;
   localparam logic [2:0] WB     = 3'd5;
   localparam logic [2:0] HALT   = 3'd6;

   localparam logic [15:0] HALT_INSN = 16'hFFFF;

   // addi/lw/sw use the adder for address/immediate math; branches compare via subtract
   function automatic logic [3:0] alu_ctrl_of(input logic [3:0] op);
      case (op)
         OP_SUB, OP_BEQ, OP_BNE: return ALU_SUB;
         OP_AND:                 return ALU_AND;
         OP_OR:                  return ALU_OR;
         OP_NOR:                 return ALU_NOR;
         OP_NAND:                return ALU_NAND;
         OP_SLT:                 return ALU_SLT;
         default:                return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/alu_param.sv
// Parametrised combinational ALU with zero flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none, output follows inputs.
module alu_param
   import cpu_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [3:0]        ctrl,
   output logic [DATA_W-1:0] result,
   output logic              zero
);

   always_comb begin
      result = '0;
      case (ctrl)
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_SLT:  result = DATA_W'($signed(a) < $signed(b));
         ALU_NOR:  result = ~(a | b);
         ALU_NAND: result = ~(a & b);
         default:  result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle 16-bit-ISA CPU on a unified req/ready memory bus; INSTR_COUNT_EN adds a retired counter.
// Latency (zero-wait): R-type/addi/sw 4 cycles, lw 5, branch/nop 3.
// Backpressure: FETCH and MEM hold with a stable request until mem_ready is seen.
module multicycle_cpu
   import cpu_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int PC_W   = 16,
   parameter int REG_AW = 2
) (
   input  logic              clock,
   input  logic              reset_n,
   output logic              mem_req,
   output logic              mem_we,
   output logic [PC_W-1:0]   mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [PC_W-1:0]   pc,
   output logic [15:0]       ir,
   output logic [DATA_W-1:0] alu_out,
   output logic              halted,
   output logic [31:0]       retired_cnt
);

   localparam int NREG = 1 << REG_AW;

   logic [2:0]        state;
   logic [DATA_W-1:0] regs [NREG];
   logic [DATA_W-1:0] a_reg;
   logic [DATA_W-1:0] b_reg;
   logic [DATA_W-1:0] load_dat;

   logic [3:0]        opcode;
   logic [REG_AW-1:0] rs_idx, rt_idx, rd_idx, wr_idx;
   logic [DATA_W-1:0] rd_a, rd_b, imm_ext, op_b, alu_res, wb_dat;
   logic [PC_W-1:0]   br_off;
   logic              alu_zero, is_rtype, is_mem_op, is_alu_op, is_branch, br_taken;

   assign opcode  = ir[15:12];
   assign rs_idx  = REG_AW'(ir[11:10]);
   assign rt_idx  = REG_AW'(ir[9:8]);
   assign rd_idx  = REG_AW'(ir[7:6]);
   assign imm_ext = {{(DATA_W-8){ir[7]}}, ir[7:0]};
   assign br_off  = {{(PC_W-9){ir[7]}}, ir[7:0], 1'b0};

   assign is_rtype  = (opcode <= OP_SLT);
   assign is_mem_op = (opcode == OP_LW) || (opcode == OP_SW);
   assign is_alu_op = is_rtype || (opcode == OP_ADDI) || is_mem_op;
   assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
   assign br_taken  = (opcode == OP_BEQ) ? alu_zero : !alu_zero;

   // R0 is hardwired to zero on read; writes to it are dropped in WB
   assign rd_a = (rs_idx == '0) ? '0 : regs[rs_idx];
   assign rd_b = (rt_idx == '0) ? '0 : regs[rt_idx];

   assign op_b   = (opcode == OP_ADDI || is_mem_op) ? imm_ext : b_reg;
   assign wr_idx = is_rtype ? rd_idx : rt_idx;
   assign wb_dat = (opcode == OP_LW) ? load_dat : alu_out;

   alu_param #(.DATA_W(DATA_W)) u_alu (
      .a      (a_reg),
      .b      (op_b),
      .ctrl   (alu_ctrl_of(opcode)),
      .result (alu_res),
      .zero   (alu_zero)
   );

   // Bus outputs are pure state decode so reset drops the request immediately
   assign mem_req   = (state == FETCH) || (state == MEM);
   assign mem_we    = (state == MEM) && (opcode == OP_SW);
   assign mem_addr  = (state == FETCH) ? pc : PC_W'(alu_out);
   assign mem_wdata = b_reg;
   assign halted    = (state == HALT);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         pc       <= '0;
         ir       <= '0;
         alu_out  <= '0;
         a_reg    <= '0;
         b_reg    <= '0;
         load_dat <= '0;
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         case (state)
            IDLE: state <= FETCH;
            FETCH: begin
               if (mem_ready) begin
                  ir    <= mem_rdata[15:0];
                  pc    <= pc + PC_W'(2);
                  state <= DECODE;
               end
            end
            DECODE: begin
               a_reg <= rd_a;
               b_reg <= rd_b;
               state <= (ir == HALT_INSN) ? HALT : EXEC;
            end
            EXEC: begin
               if (is_alu_op) begin
                  alu_out <= alu_res;
                  state   <= is_mem_op ? MEM : WB;
               end else if (is_branch) begin
                  alu_out <= alu_res;
                  if (br_taken) pc <= pc + br_off;
                  state <= FETCH;
               end else begin
                  state <= FETCH;
               end
            end
            MEM: begin
               if (mem_ready) begin
                  if (opcode == OP_SW) begin
                     state <= FETCH;
                  end else begin
                     load_dat <= mem_rdata;
                     state    <= WB;
                  end
               end
            end
            WB: begin
               if (wr_idx != '0) regs[wr_idx] <= wb_dat;
               state <= FETCH;
            end
            HALT:    state <= HALT;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef INSTR_COUNT_EN
   logic        retire;
   logic [31:0] cnt_q;

   assign retire = ((state == EXEC) && !is_alu_op) ||
                   ((state == MEM) && mem_ready && (opcode == OP_SW)) ||
                   (state == WB);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)    cnt_q <= '0;
      else if (retire) cnt_q <= cnt_q + 32'd1;
   end

   assign retired_cnt = cnt_q;
`else
   assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu: vector table of ALU programs plus bus/branch/reset sequences.
module tb_multicycle_cpu;
   import cpu_pkg::*;

`ifdef INSTR_COUNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        mem_req, mem_we, mem_ready, halted;
   logic [15:0] mem_addr, mem_wdata, mem_rdata, pc, ir, alu_out;
   logic [31:0] retired_cnt;
   logic [15:0] mem [0:63];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clock = ~clock;

   multicycle_cpu #(.DATA_W(16), .PC_W(16), .REG_AW(2)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_ready   (mem_ready),
      .pc          (pc),
      .ir          (ir),
      .alu_out     (alu_out),
      .halted      (halted),
      .retired_cnt (retired_cnt)
   );

   assign mem_rdata = mem[mem_addr[6:1]];

   always @(posedge clock)
      if (mem_req && mem_we && mem_ready) mem[mem_addr[6:1]] <= mem_wdata;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   task automatic load(input logic [15:0] w0, w1, w2, w3, w4);
      for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
      mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3; mem[4] = w4;
   endtask

   task automatic restart(input logic [15:0] w0, w1, w2, w3, w4);
      reset_n   = 1'b0;
      mem_ready = 1'b1;
      @(negedge clock);
      load(w0, w1, w2, w3, w4);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic run_halt(input string name);
      int n = 0;
      while (!halted && n < 200) begin
         @(negedge clock);
         n++;
      end
      check(name, {31'd0, halted}, 32'd1);
   endtask

   task automatic wait_fetch(input string name, input logic [15:0] addr);
      int n = 0;
      while (!(dut.state == FETCH && pc == addr) && n < 100) begin
         @(negedge clock);
         n++;
      end
      check(name, {31'd0, (dut.state == FETCH && pc == addr)}, 32'd1);
   endtask

   // Cycles from FETCH at start to FETCH of the next sequential word; also records writes
   task automatic measure(input logic [15:0] start, output int n, output int wseen,
                          output logic [15:0] waddr, output logic [15:0] wdat);
      n = 0; wseen = 0; waddr = 16'h0; wdat = 16'h0;
      wait_fetch("reach_fetch", start);
      do begin
         @(negedge clock);
         n++;
         if (mem_req && mem_we) begin
            wseen++;
            waddr = mem_addr;
            wdat  = mem_wdata;
         end
      end while (!(dut.state == FETCH && pc == start + 16'd2) && n < 20);
   endtask

   typedef struct {
      string       name;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] insn;
      int          ridx;
      logic [15:0] exp_r;
      logic [15:0] exp_alu;
   } vec_t;

   vec_t vecs [11];

   initial begin
      int          n, ws;
      logic [15:0] wa, wd;

      vecs[0]  = '{"add",    8'h0F, 8'h07, 16'h06C0, 3, 16'h0016, 16'h0016};
      vecs[1]  = '{"sub",    8'h0F, 8'h07, 16'h16C0, 3, 16'h0008, 16'h0008};
      vecs[2]  = '{"sub_neg",8'h07, 8'h0F, 16'h16C0, 3, 16'hFFF8, 16'hFFF8};
      vecs[3]  = '{"and",    8'h0C, 8'h0A, 16'h26C0, 3, 16'h0008, 16'h0008};
      vecs[4]  = '{"or",     8'h0C, 8'h0A, 16'h36C0, 3, 16'h000E, 16'h000E};
      vecs[5]  = '{"nor",    8'h0C, 8'h0A, 16'h46C0, 3, 16'hFFF1, 16'hFFF1};
      vecs[6]  = '{"nand",   8'h0C, 8'h0A, 16'h56C0, 3, 16'hFFF7, 16'hFFF7};
      vecs[7]  = '{"slt_m1", 8'hFF, 8'h01, 16'h66C0, 3, 16'h0001, 16'h0001};
      vecs[8]  = '{"slt_p1", 8'h01, 8'hFF, 16'h66C0, 3, 16'h0000, 16'h0000};
      vecs[9]  = '{"addi_n", 8'h05, 8'h00, 16'h77FD, 3, 16'h0002, 16'h0002};
      vecs[10] = '{"r0_wr",  8'h05, 8'h00, 16'h7005, 0, 16'h0000, 16'h0005};

      mem_ready = 1'b1;
      load(16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
      @(negedge clock);
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_mem_we",  {31'd0, mem_we},  32'd0);
      check("rst_halted",  {31'd0, halted},  32'd0);
      check("rst_pc",      {16'd0, pc},      32'd0);
      check("rst_ir",      {16'd0, ir},      32'd0);
      check("rst_alu",     {16'd0, alu_out}, 32'd0);
      check("rst_cnt",     retired_cnt,      32'd0);
      check("rst_state",   {29'd0, dut.state}, {29'd0, IDLE});

      // ALU programs: addi R1,R0,a; addi R2,R0,b; insn; halt
      foreach (vecs[k]) begin
         restart({8'h71, vecs[k].a}, {8'h72, vecs[k].b}, vecs[k].insn, HALT_INSN, 16'h0);
         run_halt({vecs[k].name, "_halt"});
         check({vecs[k].name, "_reg"}, {16'd0, dut.regs[vecs[k].ridx]}, {16'd0, vecs[k].exp_r});
         check({vecs[k].name, "_alu"}, {16'd0, alu_out}, {16'd0, vecs[k].exp_alu});
         check({vecs[k].name, "_pc"},  {16'd0, pc}, 32'd8);
         check({vecs[k].name, "_cnt"}, retired_cnt, CNT_ON ? 32'd3 : 32'd0);
      end

      // FETCH wait states
      restart(16'h710F, HALT_INSN, 16'h0, 16'h0, 16'h0);
      mem_ready = 1'b0;
      @(negedge clock);
      for (int i = 0; i < 3; i++) begin
         check("fw_state", {29'd0, dut.state}, {29'd0, FETCH});
         check("fw_addr",  {16'd0, mem_addr}, 32'd0);
         check("fw_ir",    {16'd0, ir}, 32'd0);
         @(negedge clock);
      end
      mem_ready = 1'b1;
      @(negedge clock);
      check("fw_ir_upd", {16'd0, ir}, 32'h710F);
      check("fw_pc",     {16'd0, pc}, 32'd2);
      check("fw_decode", {29'd0, dut.state}, {29'd0, DECODE});

      // sw R1,0(R0) then lw R3,0(R0)
      restart(16'h710F, 16'h9100, 16'h8300, HALT_INSN, 16'h0);
      measure(16'd2, n, ws, wa, wd);
      check("sw_cycles", n, 4);
      check("sw_writes", ws, 1);
      check("sw_addr",   {16'd0, wa}, 32'd0);
      check("sw_wdata",  {16'd0, wd}, 32'd15);
      measure(16'd4, n, ws, wa, wd);
      check("lw_cycles", n, 5);
      check("lw_no_wr",  ws, 0);
      run_halt("lsu_halt");
      check("lw_r3",  {16'd0, dut.regs[3]}, 32'd15);
      check("sw_mem", {16'd0, mem[0]}, 32'd15);
      check("lsu_cnt", retired_cnt, CNT_ON ? 32'd3 : 32'd0);

      // bne R1,R2,-2 at pc=6: taken loops to itself, not taken falls through
      restart(16'h710F, 16'h7207, 16'h7301, 16'hB6FF, HALT_INSN);
      wait_fetch("bne_t_reach", 16'd6);
      repeat (3) @(negedge clock);
      check("bne_t_state", {29'd0, dut.state}, {29'd0, FETCH});
      check("bne_t_pc",    {16'd0, pc}, 32'd6);
      restart(16'h710F, 16'h720F, 16'h7301, 16'hB6FF, HALT_INSN);
      wait_fetch("bne_n_reach", 16'd6);
      repeat (3) @(negedge clock);
      check("bne_n_state", {29'd0, dut.state}, {29'd0, FETCH});
      check("bne_n_pc",    {16'd0, pc}, 32'd8);
      run_halt("bne_n_halt");
      check("bne_n_cnt", retired_cnt, CNT_ON ? 32'd4 : 32'd0);

      // Reset while sw waits in MEM
      restart(16'h710F, 16'h9110, HALT_INSN, 16'h0, 16'h0);
      n = 0;
      while (!(dut.state == EXEC && pc == 16'd4) && n < 50) begin
         @(negedge clock);
         n++;
      end
      mem_ready = 1'b0;
      @(negedge clock);
      check("mw_state", {29'd0, dut.state}, {29'd0, MEM});
      check("mw_req",   {31'd0, mem_req}, 32'd1);
      check("mw_we",    {31'd0, mem_we}, 32'd1);
      check("mw_addr",  {16'd0, mem_addr}, 32'h10);
      @(negedge clock);
      check("mw_addr_hold",  {16'd0, mem_addr}, 32'h10);
      check("mw_wdata_hold", {16'd0, mem_wdata}, 32'd15);
      #2 reset_n = 1'b0;
      #1;
      check("ra_req",   {31'd0, mem_req}, 32'd0);
      check("ra_we",    {31'd0, mem_we}, 32'd0);
      check("ra_pc",    {16'd0, pc}, 32'd0);
      check("ra_state", {29'd0, dut.state}, {29'd0, IDLE});
      check("ra_mem",   {16'd0, mem[8]}, 32'd0);
      for (int i = 0; i < 4; i++) check("ra_regs", {16'd0, dut.regs[i]}, 32'd0);
      @(negedge clock);
      reset_n   = 1'b1;
      mem_ready = 1'b1;
      check("rr_idle", {29'd0, dut.state}, {29'd0, IDLE});
      @(negedge clock);
      check("rr_fetch", {29'd0, dut.state}, {29'd0, FETCH});
      check("rr_addr",  {16'd0, mem_addr}, 32'd0);
      check("rr_cnt",   retired_cnt, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
